// File: rtl/m_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes, an
// accumulator usable as operand B, and zero/all-ones/parity result flags.
module m_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_acc,
    input  logic             i_acc_clr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_ones,
    output logic             o_parity
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_result;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] func_r;
    logic             accept;
    logic             s2_load;

    // S1 may always accept unless both stages hold data and S2 cannot drain.
    assign o_ready = !s1_valid || !s2_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign s2_load = s1_valid && (!s2_valid || i_ready);
    assign opnd_b  = i_acc ? acc : i_b;
    assign o_valid = s2_valid;

    always_comb begin
        // NOTE: default assignment first so no path leaves func_r unassigned (no latch).
        func_r = '0;
        case (op_e'(i_op))
            OP_AND:  func_r = i_a & opnd_b;
            OP_NAND: func_r = ~(i_a & opnd_b);
            OP_OR:   func_r = i_a | opnd_b;
            OP_NOR:  func_r = ~(i_a | opnd_b);
            OP_XOR:  func_r = i_a ^ opnd_b;
            OP_XNOR: func_r = ~(i_a ^ opnd_b);
            OP_NOTA: func_r = ~i_a;
            OP_PASS: func_r = i_a;
            default: func_r = '0;
        endcase
    end

    // Stage 1 and accumulator; the op of a clearing beat already saw the old acc.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            s1_valid  <= 1'b0;
            s1_result <= '0;
            acc       <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_result <= func_r;
            acc       <= i_acc_clr ? '0 : func_r;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2 holds result and flags stable while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            o_result <= '0;
            o_zero   <= 1'b0;
            o_ones   <= 1'b0;
            o_parity <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            o_result <= s1_result;
            o_zero   <= ~|s1_result;
            o_ones   <= &s1_result;
            o_parity <= ^s1_result;
        end else if (s2_valid && i_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: doc/m_logic_unit.md
# m_logic_unit

Parametrised, pipelined bitwise logic unit: the successor to the fixed 1-bit gate block. It applies one of eight opcode-selected logic functions to two WIDTH-bit operands. Operand B can be replaced by an internal accumulator, so operations can be chained. Transfers use valid/ready handshakes, and each result carries zero, all-ones and parity flags. It sits between a register-file/operand source and a result consumer in the datapath labs.

## Interface
- WIDTH, 8: operand/result width in bits (≥1)
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_valid  input  1  operand beat valid
- o_ready  output  1  unit can accept a beat this cycle
- i_op  input  3  opcode: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B (ignored when i_acc=1 or op 6/7)
- i_acc  input  1  use accumulator as operand B
- i_acc_clr  input  1  clear accumulator (sampled only when beat accepted)
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_result  output  WIDTH  result
- o_zero  output  1  result == 0
- o_ones  output  1  result == all ones
- o_parity  output  1  XOR reduction of result

## Operation
- Accept: i_valid && o_ready at a rising edge. Output transfer: o_valid && i_ready.
- Stage 1 (S1), on accept:
  - Compute r = f(i_op, A, B), with B = i_acc ? acc : i_b.
  - Register r and set s1_valid.
  - acc <= r on every accepted beat, regardless of i_acc.
- Accumulator clear:
  - i_acc_clr on an accepted beat: acc <= 0. Clear has priority over the update.
  - The op in that same beat still uses the pre-clear acc as B.
  - i_acc_clr without an accepted beat is ignored.
- Stage 2 (S2):
  - Loads from S1 when s1_valid && (!s2_valid || i_ready).
  - Computes flags from the S1 result and registers them with it.
  - o_valid = s2_valid. o_result and flags are S2 registers.
- Stage clearing:
  - S1 clears when it moves to S2 with no new accept.
  - S2 clears when its result is consumed and S1 is empty.
- o_ready = !s1_valid || !s2_valid || i_ready (combinational from state and i_ready).
- Capacity: 2 beats. Full = s1_valid && s2_valid && !i_ready → o_ready=0.
- Opcodes act bitwise over all WIDTH bits. Ops 6 and 7 ignore B but still update acc.
- Held output: while o_valid && !i_ready, o_result and flags are held stable.
- No reordering or dropping; results leave in acceptance order.
- Accumulator chaining: acc reflects the last accepted beat, so back-to-back i_acc=1 beats chain correctly without stalls.

## Timing
- Reset (async assert, synchronous-release use):
  - o_valid=0, o_result=0, o_zero=0, o_ones=0, o_parity=0.
  - acc=0, s1_valid=0.
  - o_ready=1 while held in reset and after release.
- Latency: accept at edge N → o_valid=1 after edge N+1, when S2 is free.
- Throughput: 1 beat/cycle with i_ready held high.
- Simultaneous output consume and new accept when full: allowed. S2←S1 and S1←new at the same edge.
- Reset mid-operation: in-flight beats are discarded and acc is cleared immediately, with no clock edge required.
- i_op, i_a, i_b, i_acc, i_acc_clr are sampled only on accept and are don't-care otherwise.

## Test plan
- **Reset values:** assert i_rst_n=0 mid-stream with 2 beats in flight → o_valid, o_result and flags read 0 immediately, o_ready=1. First beat accepted after release gets latency 2.
- **All opcodes:** with WIDTH=8, A=8'hCA, B=8'h5F, ops 0..7 → results 4A, B5, DF, 20, 95, 6A, 35, CA. Parity of 4A=1; zero=0 and ones=0 throughout.
- **Flags:** XOR A=B=8'h3C → result 00, o_zero=1, o_parity=0. OR A=F0, B=0F → result FF, o_ones=1, o_parity=0.
- **Accumulator chain:**
  - Beats: PASS 8'h0F; XOR i_acc=1 A=8'hFF; AND i_acc=1 A=8'h3C → results 0F, F0, 30.
  - Next beat with i_acc_clr=1 (OR, i_acc=1, A=01) → result 31. Following OR i_acc=1 A=01 → result 01.
- **Backpressure:** i_ready=0 while 3 beats offered back-to-back → 2 accepted, o_ready=0 on the third, o_result held stable. Raise i_ready → all 3 delivered in order, one per cycle.
- **Streaming:** 16 random beats with i_valid and i_ready held high → one result per cycle after 2-cycle fill, matching the reference model in order.
